pc_unit_param: RTL and testbench

- Parametrised next-generation program-counter unit for the Gumnut-class core.
- Merges PC register, next-PC selection, a DEPTH-entry return-address stack and a single-level interrupt save register.
- Adds over the current generation: configurable address/displacement widths, stack full/empty status, sticky overflow/underflow/interrupt-misuse error flags, and a configurable reset/ISR vector.
- Sits between the control unit (pc_op, pc_en) and instruction memory (pc_o drives instruction address).

---
 rtl/pc_unit_param.sv | 189 ++++++++++++++++++
 tb/tb_pc_unit_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_param.sv
// Program-counter unit: PC register, next-PC selection, LIFO return-address
// stack and a single-level interrupt save register with sticky error flags.
module pc_unit_param #(
  parameter int                ADDR_W   = 12,
  parameter int                DISP_W   = 8,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] ISR_VEC  = ADDR_W'(1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cen,
  input  logic                         pc_en,
  input  logic [3:0]                   pc_op,
  input  logic                         zero_i,
  input  logic                         carry_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DISP_W-1:0]            disp_i,
  input  logic                         err_clr,
  output logic [ADDR_W-1:0]            pc_o,
  output logic                         intz_o,
  output logic                         intc_o,
  output logic                         int_active_o,
  output logic [$clog2(DEPTH+1)-1:0]   sp_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         ovf_o,
  output logic                         unf_o,
  output logic                         int_err_o
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [3:0] OP_INC  = 4'd0;
  localparam logic [3:0] OP_BZ   = 4'd1;
  localparam logic [3:0] OP_BNZ  = 4'd2;
  localparam logic [3:0] OP_BC   = 4'd3;
  localparam logic [3:0] OP_BNC  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_JSB  = 4'd6;
  localparam logic [3:0] OP_RET  = 4'd7;
  localparam logic [3:0] OP_INT  = 4'd8;
  localparam logic [3:0] OP_RETI = 4'd9;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              intz_q, intz_d;
  logic              intc_q, intc_d;
  logic              act_q, act_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              ierr_q, ierr_d;

  logic [ADDR_W-1:0] stk_q [DEPTH];
  logic              push;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] tgt;
  logic              full;
  logic              empty;

  // Sign-extends the displacement and adds it to the sequential PC; wraps.
  function automatic logic [ADDR_W-1:0] branch_target(
    input logic [ADDR_W-1:0] base,
    input logic [DISP_W-1:0] disp
  );
    logic signed [DISP_W-1:0] ds;
    logic signed [ADDR_W-1:0] ext;
    ds  = disp;
    ext = ADDR_W'(ds);
    return base + ext;
  endfunction

  assign seq      = pc_q + ADDR_W'(1);
  assign tgt      = branch_target(seq, disp_i);
  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    pc_d       = pc_q;
    sp_d       = sp_q;
    saved_pc_d = saved_pc_q;
    intz_d     = intz_q;
    intc_d     = intc_q;
    act_d      = act_q;
    ovf_d      = ovf_q  & ~err_clr;
    unf_d      = unf_q  & ~err_clr;
    ierr_d     = ierr_q & ~err_clr;
    push       = 1'b0;
    if (pc_en) begin
      case (pc_op)
        OP_INC: pc_d = seq;
        OP_BZ:  pc_d = zero_i   ? tgt : seq;
        OP_BNZ: pc_d = !zero_i  ? tgt : seq;
        OP_BC:  pc_d = carry_i  ? tgt : seq;
        OP_BNC: pc_d = !carry_i ? tgt : seq;
        OP_JMP: pc_d = addr_i;
        OP_JSB: begin
          pc_d = addr_i;
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_d  = seq;
            unf_d = 1'b1;
          end else begin
            pc_d = stk_q[top_idx];
            sp_d = sp_q - SP_W'(1);
          end
        end
        OP_INT: begin
          if (act_q) begin
            pc_d   = seq;
            ierr_d = 1'b1;
          end else begin
            saved_pc_d = pc_q;
            intz_d     = zero_i;
            intc_d     = carry_i;
            act_d      = 1'b1;
            pc_d       = ISR_VEC;
          end
        end
        OP_RETI: begin
          if (act_q) begin
            pc_d  = saved_pc_q;
            act_d = 1'b0;
          end else begin
            pc_d   = seq;
            ierr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      sp_q       <= '0;
      saved_pc_q <= '0;
      intz_q     <= 1'b0;
      intc_q     <= 1'b0;
      act_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      ierr_q     <= 1'b0;
    end else if (cen) begin
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      saved_pc_q <= saved_pc_d;
      intz_q     <= intz_d;
      intc_q     <= intc_d;
      act_q      <= act_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      ierr_q     <= ierr_d;
    end
  end

  // Stack storage carries no reset; only sp_q defines which entries are live.
  always_ff @(posedge clk) begin
    if (cen && push) begin
      stk_q[push_idx] <= seq;
    end
  end

  assign pc_o         = pc_q;
  assign intz_o       = intz_q;
  assign intc_o       = intc_q;
  assign int_active_o = act_q;
  assign sp_o         = sp_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign ovf_o        = ovf_q;
  assign unf_o        = unf_q;
  assign int_err_o    = ierr_q;

endmodule

// File: tb/tb_pc_unit_param.sv
// Bench for pc_unit_param: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_pc_unit_param;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int SPW = $clog2(DEP + 1);
  localparam logic [AW-1:0] RST_PC = 12'h000;
  localparam logic [AW-1:0] ISR    = 12'h001;

  logic clk = 1'b0, rst = 1'b0, cen = 1'b1, pc_en = 1'b0;
  logic zero_i = 1'b0, carry_i = 1'b0, err_clr = 1'b0;
  logic [3:0]    pc_op  = 4'd0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] disp_i = '0;

  logic [AW-1:0]  pc_o;
  logic           intz_o, intc_o, int_active_o, full_o, empty_o, ovf_o, unf_o, int_err_o;
  logic [SPW-1:0] sp_o;

  pc_unit_param #(.ADDR_W(AW), .DISP_W(DW), .DEPTH(DEP), .RESET_PC(RST_PC), .ISR_VEC(ISR)) dut (
    .clk(clk), .rst(rst), .cen(cen), .pc_en(pc_en), .pc_op(pc_op),
    .zero_i(zero_i), .carry_i(carry_i), .addr_i(addr_i), .disp_i(disp_i),
    .err_clr(err_clr), .pc_o(pc_o), .intz_o(intz_o), .intc_o(intc_o),
    .int_active_o(int_active_o), .sp_o(sp_o), .full_o(full_o), .empty_o(empty_o),
    .ovf_o(ovf_o), .unf_o(unf_o), .int_err_o(int_err_o)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  logic [AW-1:0] m_pc, m_saved;
  logic          m_z, m_c, m_act, m_ovf, m_unf, m_ierr;
  logic [AW-1:0] m_stk [$];

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_saved = '0;
    m_z = 0; m_c = 0; m_act = 0; m_ovf = 0; m_unf = 0; m_ierr = 0;
    m_stk.delete();
  endtask

  // Next state of the program counter from the current inputs.
  task automatic model_step();
    int d;
    int seq;
    int tgt;
    if (!rst || !cen) return;
    if (err_clr) begin m_ovf = 0; m_unf = 0; m_ierr = 0; end
    if (!pc_en) return;
    d = int'(disp_i);
    if (d >= (1 << (DW - 1))) d = d - (1 << DW);
    seq = (int'(m_pc) + 1) % (1 << AW);
    tgt = (int'(m_pc) + 1 + d + (1 << AW)) % (1 << AW);
    case (int'(pc_op))
      0: m_pc = AW'(seq);
      1: m_pc = AW'(zero_i   ? tgt : seq);
      2: m_pc = AW'(!zero_i  ? tgt : seq);
      3: m_pc = AW'(carry_i  ? tgt : seq);
      4: m_pc = AW'(!carry_i ? tgt : seq);
      5: m_pc = addr_i;
      6: begin
        if (m_stk.size() < DEP) m_stk.push_back(AW'(seq));
        else m_ovf = 1;
        m_pc = addr_i;
      end
      7: begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = AW'(seq); m_unf = 1; end
      end
      8: begin
        if (!m_act) begin
          m_saved = m_pc; m_z = zero_i; m_c = carry_i; m_act = 1; m_pc = ISR;
        end else begin
          m_pc = AW'(seq); m_ierr = 1;
        end
      end
      9: begin
        if (m_act) begin m_pc = m_saved; m_act = 0; end
        else begin m_pc = AW'(seq); m_ierr = 1; end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", int'(pc_o), int'(m_pc));
      check("sp", int'(sp_o), m_stk.size());
      check("full", int'(full_o), int'(m_stk.size() == DEP));
      check("empty", int'(empty_o), int'(m_stk.size() == 0));
      check("ovf", int'(ovf_o), int'(m_ovf));
      check("unf", int'(unf_o), int'(m_unf));
      check("int_err", int'(int_err_o), int'(m_ierr));
      check("int_active", int'(int_active_o), int'(m_act));
      check("intz", int'(intz_o), int'(m_z));
      check("intc", int'(intc_o), int'(m_c));
    end
  end

  task automatic drive(input logic c, input logic en, input logic [3:0] op, input logic z,
                       input logic cy, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic clr);
    @(negedge clk); #1;
    cen = c; pc_en = en; pc_op = op; zero_i = z; carry_i = cy;
    addr_i = a; disp_i = d; err_clr = clr;
    model_step();
  endtask

  task automatic post();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 0; cen = 1; pc_en = 0; err_clr = 0;
    model_reset();
    #1;
    check("rst_now_pc", int'(pc_o), int'(RST_PC));
    check("rst_now_sp", int'(sp_o), 0);
    @(negedge clk); #1;
    rst = 1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_pc", int'(pc_o), 0);
    check("reset_empty", int'(empty_o), 1);
    check("reset_act", int'(int_active_o), 0);
    @(negedge clk); #1;
    rst = 1;

    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 4'd0, 0, 0, '0, '0, 0); post();
      check("inc_seq", int'(pc_o), i);
    end

    drive(1, 1, 4'd5, 0, 0, 12'h010, '0, 0);
    drive(1, 1, 4'd1, 1, 0, '0, 8'hFC, 0); post();
    check("bz_taken", int'(pc_o), 'h00D);
    drive(1, 1, 4'd5, 0, 0, 12'h010, '0, 0);
    drive(1, 1, 4'd1, 0, 0, '0, 8'hFC, 0); post();
    check("bz_not_taken", int'(pc_o), 'h011);
    drive(1, 1, 4'd5, 0, 0, 12'hFFF, '0, 0);
    drive(1, 1, 4'd0, 0, 0, '0, '0, 0); post();
    check("pc_wrap", int'(pc_o), 'h000);
    drive(1, 1, 4'd5, 0, 0, 12'h100, '0, 0);
    drive(1, 1, 4'd3, 0, 1, '0, 8'h05, 0); post();
    check("bc_taken", int'(pc_o), 'h106);

    drive(1, 1, 4'd5, 0, 0, 12'h020, '0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 4'd6, 0, 0, 12'h100, '0, 0); post();
      check("jsb_sp", int'(sp_o), (i < 8) ? i + 1 : 8);
      check("jsb_ovf", int'(ovf_o), int'(i == 8));
    end
    check("jsb_full", int'(full_o), 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 4'd7, 0, 0, '0, '0, 0); post();
      check("ret_order", int'(pc_o), (i < 7) ? 'h101 : 'h021);
    end
    check("ret_empty", int'(empty_o), 1);

    drive(1, 1, 4'd5, 0, 0, 12'h050, '0, 0);
    drive(1, 1, 4'd7, 0, 0, '0, '0, 0); post();
    check("ret_unf_pc", int'(pc_o), 'h051);
    check("ret_unf", int'(unf_o), 1);
    drive(1, 0, 4'd0, 0, 0, '0, '0, 1); post();
    check("clr_unf", int'(unf_o), 0);
    check("clr_ovf", int'(ovf_o), 0);
    drive(1, 1, 4'd7, 0, 0, '0, '0, 1); post();
    check("clr_vs_event", int'(unf_o), 1);
    drive(1, 0, 4'd0, 0, 0, '0, '0, 1);

    drive(1, 1, 4'd5, 0, 0, 12'h030, '0, 0);
    drive(1, 1, 4'd8, 1, 0, '0, '0, 0); post();
    check("int_pc", int'(pc_o), 'h001);
    check("int_act", int'(int_active_o), 1);
    check("int_z", int'(intz_o), 1);
    check("int_c", int'(intc_o), 0);
    drive(1, 1, 4'd8, 0, 1, '0, '0, 0); post();
    check("int2_pc", int'(pc_o), 'h002);
    check("int2_err", int'(int_err_o), 1);
    drive(1, 1, 4'd9, 0, 0, '0, '0, 0); post();
    check("reti_pc", int'(pc_o), 'h030);
    check("reti_act", int'(int_active_o), 0);
    check("reti_z_hold", int'(intz_o), 1);
    drive(1, 1, 4'd12, 0, 0, 12'h777, 8'h11, 0); post();
    check("op12_hold", int'(pc_o), 'h030);

    for (int i = 0; i < 3; i++) drive(1, 1, 4'd6, 0, 0, 12'h200, '0, 0);
    post();
    check("stk3_sp", int'(sp_o), 3);
    drive(0, 1, 4'd6, 0, 0, 12'h300, '0, 0); post();
    check("cen0_pc", int'(pc_o), 'h200);
    check("cen0_sp", int'(sp_o), 3);
    do_reset();

    repeat (600) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom), DW'($urandom), 1'($urandom_range(0, 15) == 0));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
